vcb_bin2bcd: RTL and testbench
==============================

# vcb_bin2bcd

Sequential binary-to-BCD converter for the 10-bit count produced by the decimal up/down counters (range 1..999).
- Runs the shift-and-add-3 (double-dabble) algorithm over one binary bit per clock.
- Delivers three packed BCD digits with a start/busy/done handshake.
- Sits between the counter's Q output and the 7-segment display multiplexer.
- Reports out-of-range inputs (> 999) and saturates the displayed value instead of wrapping.

## Interface
Parameters:
- WIDTH, 10, binary input width.
- DIGITS, 3, number of BCD output digits (4 bits each).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- clr_n  in  1  reset, asynchronous and active-low; forces the reset state immediately.
- start  in  1  request conversion of bin; sampled only in IDLE.
- bin  in  WIDTH  unsigned binary value; captured on the accepting edge only.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when bcd/ovf are updated.
- bcd  out  4*DIGITS  result; digit 0 in bits [3:0] (units), digit DIGITS-1 in the MSBs.
- ovf  out  1  last captured bin exceeded 10^DIGITS-1.

## Operation
- States: IDLE, SHIFT.
- **IDLE, start=1 (accepting edge):**
  - Load the working register {BCD field = 0, bin} (WIDTH + 4*DIGITS bits).
  - Clear the bit counter.
  - Latch ovf_pend = (bin > 10^DIGITS-1).
  - Go to SHIFT; busy = 1.
- **IDLE, start=0:** hold all state.
- **SHIFT, each edge:**
  - Add 3 to every BCD nibble of the working register that is ≥ 5, then shift the whole register left by 1.
  - Increment the counter.
- **On the WIDTH-th shift:**
  - Write bcd from the shifted BCD field, or all-nines (0x999 for DIGITS=3) if ovf_pend.
  - ovf = ovf_pend.
  - done = 1 for one cycle; busy = 0; return to IDLE.
- start while busy is ignored; it is not queued.
- bcd and ovf hold their value between conversions and change only on the done edge.
- All arithmetic is unsigned. Nibble correction is 4-bit with no carry out; a corrected nibble is at most 12, so no carry is possible.

## Timing
- Reset values (clr_n low, asynchronous):
  - state = IDLE; busy = 0; done = 0; ovf = 0.
  - bcd = 0; working register = 0; counter = 0.
- Reset mid-conversion aborts the conversion: no done pulse, and bcd keeps its reset value 0.
- Counting edges from the accepting edge E0:
  - busy is high from E0 through E0+WIDTH−1 and low after E0+WIDTH.
  - done is high for exactly the cycle following edge E0+WIDTH.
  - Latency is WIDTH clocks (10 by default).
- Throughput: a new start may be accepted at E0+WIDTH+1 (the cycle in which done is high), giving one conversion per WIDTH+1 clocks.
- Simultaneous start and done: start is ignored at the done edge itself (the FSM is still in SHIFT) and accepted on the next edge if still high.
- bin need only be stable at the accepting edge.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared package `vcb_pkg` holds:
  - the state enum {IDLE, SHIFT};
  - constants WIDTH_DEF = 10, DIGITS_DEF = 3;
  - the BCD saturation constant (all-nines).
- Sub-module `bcd_digit_adj`: combinational, 4-bit in/out, applies add-3 when the input is ≥ 5. Instantiated DIGITS times via generate.
- Top level owns the FSM, bit counter (clog2(WIDTH+1) bits), working register, and output registers.

## Test plan
- **In range:** bin = 999, start pulse → after 10 clocks bcd = 0x999, ovf = 0, done high for 1 cycle, busy high for exactly 10 cycles.
- **Small values:** bin = 0 → bcd = 0x000; bin = 1 → bcd = 0x001; bin = 507 → bcd = 0x507. ovf = 0 in all three.
- **Overflow:** bin = 1023 → bcd = 0x999 saturated, ovf = 1. A following bin = 42 → bcd = 0x042, ovf = 0.
- **Start while busy:** start held high with bin changing 250→700 mid-conversion → result 0x250. The next conversion begins on the edge after done and yields 0x700.
- **Reset mid-conversion:** clr_n low at cycle 5 of a conversion → busy = 0, done never pulses, bcd = 0x000. A fresh start with bin = 123 → 0x123.
- **Back-to-back:** start held high with bin = 500 then 37 → done pulses 11 clocks apart, results 0x500 then 0x037.

Source files
------------

// File: rtl/vcb_pkg.sv
// rtl/vcb_pkg.sv - shared types and constants for the binary-to-BCD converter
package vcb_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int WIDTH_DEF  = 10;
  localparam int DIGITS_DEF = 3;

  function automatic logic [31:0] bcd_all_nines(input int digits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (i < digits) r[4*i +: 4] = 4'h9;
    return r;
  endfunction

  function automatic longint unsigned pow10(input int digits);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < digits; i++) r = r * 10;
    return r;
  endfunction

  localparam logic [4*DIGITS_DEF-1:0] BCD_SAT = (4*DIGITS_DEF)'(bcd_all_nines(DIGITS_DEF));

endpackage

// File: rtl/vcb_bin2bcd_if.sv
// rtl/vcb_bin2bcd_if.sv - start/busy/done handshake bundle for vcb_bin2bcd
import vcb_pkg::*;

interface vcb_bin2bcd_if #(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  modport master (output start, bin, input busy, done, bcd, ovf);
  modport slave  (input start, bin, output busy, done, bcd, ovf);
endinterface

// File: rtl/vcb_bin2bcd_bcd_digit_adj.sv
// rtl/vcb_bin2bcd_bcd_digit_adj.sv - double-dabble nibble correction (add 3 when >= 5)
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  // A corrected nibble never exceeds 12, so the 4-bit add cannot carry.
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/vcb_bin2bcd.sv
// rtl/vcb_bin2bcd.sv - sequential shift-and-add-3 binary-to-BCD converter with saturation
import vcb_pkg::*;

module vcb_bin2bcd #(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input logic          clk,
  input logic          clr_n,
  vcb_bin2bcd_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int RW = WIDTH + BW;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);
  localparam logic [BW-1:0]     SAT  = BW'(bcd_all_nines(DIGITS));
  localparam longint unsigned   MAXV = pow10(DIGITS) - 1;

  state_t          state;
  logic [RW-1:0]   work;
  logic [CW-1:0]   cnt;
  logic            ovf_pend;
  logic            busy_q, done_q, ovf_q;
  logic [BW-1:0]   bcd_q;
  logic [BW-1:0]   adj;
  logic [RW-1:0]   shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (.d(work[WIDTH + 4*g +: 4]), .q(adj[4*g +: 4]));
  end

  // The top corrected bit is always zero for in-range counts, so dropping it is lossless.
  assign shifted = {adj[BW-2:0], work[WIDTH-1:0], 1'b0};

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      work     <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      bcd_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            work     <= {BW'(0), bus.bin};
            cnt      <= '0;
            ovf_pend <= 64'(bus.bin) > MAXV;
            busy_q   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            bcd_q  <= ovf_pend ? SAT : shifted[RW-1 -: BW];
            ovf_q  <= ovf_pend;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_vcb_bin2bcd.sv
// tb/tb_vcb_bin2bcd.sv - directed self-checking bench for vcb_bin2bcd
module tb_vcb_bin2bcd;
  logic clk;
  logic clr_n;
  int   total = 0;
  int   bad   = 0;

  vcb_bin2bcd_if #(.WIDTH(10), .DIGITS(3)) bus ();

  vcb_bin2bcd #(.WIDTH(10), .DIGITS(3)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after done drops.
  task automatic conv(input logic [9:0] v, input logic [11:0] eb, input logic eo, input string tag);
    int busy_cyc;
    int t;
    busy_cyc = 0;
    t = 0;
    bus.bin   = v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.done && t < 40) begin
      if (bus.busy) busy_cyc++;
      t++;
      @(negedge clk);
    end
    chk({tag, ".done"}, 32'(bus.done), 32'd1);
    chk({tag, ".bcd"},  32'(bus.bcd),  32'(eb));
    chk({tag, ".ovf"},  32'(bus.ovf),  32'(eo));
    chk({tag, ".busy_cycles"}, 32'(busy_cyc), 32'd10);
    chk({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk({tag, ".done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  // start held high; bin switches to v2 right after the first accepting edge.
  task automatic b2b(input logic [9:0] v1, input logic [9:0] v2,
                     input logic [11:0] e1, input logic [11:0] e2, input string tag);
    int t;
    t = 0;
    bus.bin   = v1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.bin = v2;
    while (!bus.done && t < 40) begin
      t++;
      @(negedge clk);
    end
    chk({tag, ".first_done"}, 32'(bus.done), 32'd1);
    chk({tag, ".first_bcd"},  32'(bus.bcd),  32'(e1));
    t = 0;
    @(negedge clk);
    t++;
    bus.start = 1'b0;
    chk({tag, ".busy_after_done"}, 32'(bus.busy), 32'd1);
    while (!bus.done && t < 40) begin
      t++;
      @(negedge clk);
    end
    chk({tag, ".done_spacing"}, 32'(t), 32'd11);
    chk({tag, ".second_bcd"},   32'(bus.bcd), 32'(e2));
    chk({tag, ".second_ovf"},   32'(bus.ovf), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    clr_n     = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.ovf",  32'(bus.ovf),  32'd0);
    chk("reset.bcd",  32'(bus.bcd),  32'd0);
    clr_n = 1'b1;
    @(negedge clk);

    conv(10'd999, 12'h999, 1'b0, "max_in_range");
    bus.bin = 10'd5;
    repeat (3) @(negedge clk);
    chk("hold.bcd",  32'(bus.bcd),  32'h999);
    chk("hold.busy", 32'(bus.busy), 32'd0);

    conv(10'd0,    12'h000, 1'b0, "zero");
    conv(10'd1,    12'h001, 1'b0, "one");
    conv(10'd507,  12'h507, 1'b0, "v507");
    conv(10'd1023, 12'h999, 1'b1, "overflow");
    conv(10'd42,   12'h042, 1'b0, "after_ovf");

    b2b(10'd250, 10'd700, 12'h250, 12'h700, "start_while_busy");
    b2b(10'd500, 10'd37,  12'h500, 12'h037, "back_to_back");

    bus.bin   = 10'd456;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    clr_n = 1'b0;
    #1;
    chk("midreset.busy", 32'(bus.busy), 32'd0);
    chk("midreset.done", 32'(bus.done), 32'd0);
    chk("midreset.bcd",  32'(bus.bcd),  32'd0);
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("midreset.no_done", 32'(pulses),  32'd0);
    chk("midreset.bcd_kept", 32'(bus.bcd), 32'd0);
    conv(10'd123, 12'h123, 1'b0, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
